multicycle_control: RTL

- Multicycle successor to the single-cycle MIPS decoder: a Moore FSM sequencing fetch, decode, execute, memory and writeback over several cycles. Datapath resources (ALU, memory port, PC adder) are shared across cycles.
- Adds a parametrised memory wait-state counter, an instr_done pulse and illegal-opcode trapping.
- Sits between instruction register / memory port and the shared datapath.

---
 rtl/mc_ctrl_pkg.sv | 85 ++++++++
 rtl/mc_wait_counter.sv | 40 ++++
 rtl/multicycle_control.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multicycle MIPS control unit.
//   - FSM state codes (one code per sequencing step)
//   - opcode / funct field values recognised by the decoder
//   - ALUOp codes and datapath mux-select encodings
//   - itype_aluop(): ALU operation for the immediate-arithmetic group
package mc_ctrl_pkg;

   typedef logic [4:0] state_t;

   localparam state_t S_IF     = 5'd0;
   localparam state_t S_ID     = 5'd1;
   localparam state_t S_EX_R   = 5'd2;
   localparam state_t S_EX_SH  = 5'd3;
   localparam state_t S_WB_R   = 5'd4;
   localparam state_t S_EX_I   = 5'd5;
   localparam state_t S_WB_I   = 5'd6;
   localparam state_t S_EX_MEM = 5'd7;
   localparam state_t S_MEM_RD = 5'd8;
   localparam state_t S_WB_LW  = 5'd9;
   localparam state_t S_MEM_WR = 5'd10;
   localparam state_t S_BR     = 5'd11;
   localparam state_t S_JMP    = 5'd12;
   localparam state_t S_JAL    = 5'd13;
   localparam state_t S_JR     = 5'd14;
   localparam state_t S_JALR   = 5'd15;
   localparam state_t S_TRAP   = 5'd16;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_SLTIU = 6'h0b;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_SLT   = 3'b100;
   localparam logic [2:0] ALU_SLTU  = 3'b101;

   localparam logic [1:0] RD_RT = 2'b00;
   localparam logic [1:0] RD_RD = 2'b01;
   localparam logic [1:0] RD_RA = 2'b10;

   localparam logic [1:0] M2R_ALU = 2'b00;
   localparam logic [1:0] M2R_MDR = 2'b01;
   localparam logic [1:0] M2R_PC  = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_RS    = 2'b01;
   localparam logic [1:0] SRCA_SHAMT = 2'b10;

   localparam logic [1:0] SRCB_RT   = 2'b00;
   localparam logic [1:0] SRCB_4    = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM2 = 2'b11;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;
   localparam logic [1:0] PCS_RS     = 2'b11;

   function automatic logic [2:0] itype_aluop(input logic [5:0] op);
      case (op)
         OP_ANDI:  return ALU_AND;
         OP_SLTI:  return ALU_SLT;
         OP_SLTIU: return ALU_SLTU;
         default:  return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// mc_wait_counter: memory wait-state counter.
//   clk, reset : clock, synchronous active-high reset
//   clear      : force the count back to 0
//   enable     : advance while a memory access is in progress
//   last       : high in the final cycle of an access (count == MEM_LAT)
// The count wraps to 0 on the final cycle so back-to-back accesses start fresh.
import mc_ctrl_pkg::*;

module mc_wait_counter #(
   parameter int MEM_LAT = 0,
   parameter int CNT_W   = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic last
);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   assign last = (cnt_reg == CNT_W'(MEM_LAT));

   always_comb begin
      cnt_next = cnt_reg;
      if (clear)
         cnt_next = '0;
      else if (enable)
         cnt_next = last ? '0 : cnt_reg + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_reg <= '0;
      else
         cnt_reg <= cnt_next;
   end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing a multicycle MIPS datapath.
//   Inputs : clk, reset (sync, active-high), OpCode/Funct (IR fields),
//            Zero (ALU flag, consumed by the datapath's PCWriteCond gate)
//   Outputs: PC/memory/IR/register-file strobes, datapath mux selects,
//            ALUOp, instr_done (retire pulse), illegal (sticky trap flag)
// Outputs decode only the state, the wait counter and controls latched in ID,
// so they never follow OpCode combinationally.
import mc_ctrl_pkg::*;

module multicycle_control #(
   parameter int MEM_LAT = 0,
   parameter int CNT_W   = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] OpCode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic       ExtOp,
   output logic       LuOp,
   output logic [2:0] ALUOp,
   output logic       instr_done,
   output logic       illegal
);

   state_t     state_reg;
   state_t     state_next;
   logic       illegal_reg;
   logic [2:0] i_aluop_reg;
   logic       i_ext_reg;
   logic       i_lu_reg;
   logic       mem_access;
   logic       mem_last;

   // Zero only qualifies PCWriteCond inside the datapath.
   logic unused_zero;
   assign unused_zero = Zero;

   assign mem_access = (state_reg == S_IF) || (state_reg == S_MEM_RD) ||
                       (state_reg == S_MEM_WR);

   mc_wait_counter #(
      .MEM_LAT (MEM_LAT),
      .CNT_W   (CNT_W)
   ) u_wait (
      .clk    (clk),
      .reset  (reset),
      .clear  (!mem_access),
      .enable (mem_access),
      .last   (mem_last)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IF:     if (mem_last) state_next = S_ID;
         S_ID: begin
            case (OpCode)
               OP_RTYPE: begin
                  case (Funct)
                     FN_JR:                  state_next = S_JR;
                     FN_JALR:                state_next = S_JALR;
                     FN_SLL, FN_SRL, FN_SRA: state_next = S_EX_SH;
                     default:                state_next = S_EX_R;
                  endcase
               end
               OP_LW, OP_SW: state_next = S_EX_MEM;
               OP_BEQ:       state_next = S_BR;
               OP_J:         state_next = S_JMP;
               OP_JAL:       state_next = S_JAL;
               OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI:
                             state_next = S_EX_I;
               default:      state_next = S_TRAP;
            endcase
         end
         S_EX_R, S_EX_SH: state_next = S_WB_R;
         S_EX_I:          state_next = S_WB_I;
         S_EX_MEM:        state_next = (OpCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:        if (mem_last) state_next = S_WB_LW;
         S_MEM_WR:        if (mem_last) state_next = S_IF;
         S_TRAP:          state_next = S_TRAP;
         default:         state_next = S_IF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= S_IF;
         illegal_reg <= 1'b0;
         i_aluop_reg <= ALU_ADD;
         i_ext_reg   <= 1'b0;
         i_lu_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_TRAP)
            illegal_reg <= 1'b1;
         // Immediate-group controls are captured while IR is stable so that
         // EX_I remains a pure function of registered state.
         if (state_reg == S_ID) begin
            i_aluop_reg <= itype_aluop(OpCode);
            i_ext_reg   <= (OpCode != OP_ANDI);
            i_lu_reg    <= (OpCode == OP_LUI);
         end
      end
   end

   assign illegal = illegal_reg;

   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = RD_RT;
      MemtoReg    = M2R_ALU;
      ALUSrcA     = SRCA_PC;
      ALUSrcB     = SRCB_RT;
      PCSource    = PCS_ALU;
      ExtOp       = 1'b0;
      LuOp        = 1'b0;
      ALUOp       = ALU_ADD;
      instr_done  = 1'b0;
      // Reset suppresses every strobe, including one caught mid-access.
      if (!reset) begin
         case (state_reg)
            S_IF: begin
               MemRead = 1'b1;
               if (mem_last) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
                  ALUSrcB = SRCB_4;
               end
            end
            S_ID: begin
               ALUSrcB = SRCB_IMM2;
               ExtOp   = 1'b1;
            end
            S_EX_R: begin
               ALUSrcA = SRCA_RS;
               ALUOp   = ALU_FUNCT;
            end
            S_EX_SH: begin
               ALUSrcA = SRCA_SHAMT;
               ALUOp   = ALU_FUNCT;
            end
            S_WB_R: begin
               RegWrite   = 1'b1;
               RegDst     = RD_RD;
               instr_done = 1'b1;
            end
            S_EX_I: begin
               ALUSrcA = SRCA_RS;
               ALUSrcB = SRCB_IMM;
               ExtOp   = i_ext_reg;
               LuOp    = i_lu_reg;
               ALUOp   = i_aluop_reg;
            end
            S_WB_I: begin
               RegWrite   = 1'b1;
               instr_done = 1'b1;
            end
            S_EX_MEM: begin
               ALUSrcA = SRCA_RS;
               ALUSrcB = SRCB_IMM;
               ExtOp   = 1'b1;
            end
            S_MEM_RD: begin
               IorD    = 1'b1;
               MemRead = 1'b1;
            end
            S_WB_LW: begin
               RegWrite   = 1'b1;
               MemtoReg   = M2R_MDR;
               instr_done = 1'b1;
            end
            S_MEM_WR: begin
               IorD       = 1'b1;
               MemWrite   = 1'b1;
               instr_done = mem_last;
            end
            S_BR: begin
               ALUSrcA     = SRCA_RS;
               ALUOp       = ALU_SUB;
               PCWriteCond = 1'b1;
               PCSource    = PCS_ALUOUT;
               instr_done  = 1'b1;
            end
            S_JMP: begin
               PCWrite    = 1'b1;
               PCSource   = PCS_JUMP;
               instr_done = 1'b1;
            end
            S_JAL: begin
               PCWrite    = 1'b1;
               PCSource   = PCS_JUMP;
               RegWrite   = 1'b1;
               RegDst     = RD_RA;
               MemtoReg   = M2R_PC;
               instr_done = 1'b1;
            end
            S_JR: begin
               PCWrite    = 1'b1;
               PCSource   = PCS_RS;
               instr_done = 1'b1;
            end
            S_JALR: begin
               PCWrite    = 1'b1;
               PCSource   = PCS_RS;
               RegWrite   = 1'b1;
               RegDst     = RD_RD;
               MemtoReg   = M2R_PC;
               instr_done = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
